// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the memory stage.
// Word/register aliases, memory FSM states and a word-compare helper.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } mem_state_t;

    // Links and snoops work on 32-bit words, so byte offset is ignored.
    function automatic logic word_eq(word_t a, word_t b);
        return a[31:2] == b[31:2];
    endfunction
endpackage

// File: rtl/mem_access_if.sv
// Data-cache request/response bundle between the memory stage and dcache.
// master = memory stage, slave = cache side.
interface mem_access_if;
    import cpu_types_pkg::*;

    logic  dhit;
    word_t dmemload;
    logic  dmemREN;
    logic  dmemWEN;
    word_t dmemaddr;
    word_t dmemstore;

    modport master (
        input  dhit, dmemload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore
    );

    modport slave (
        output dhit, dmemload,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore
    );
endinterface

// File: rtl/link_reg.sv
// LL/SC link register: set by a retiring LL, cleared by SC, aliasing SW
// or a matching snoop invalidate.
module link_reg
    import cpu_types_pkg::*;
#(
    parameter bit LINK_EN = 1'b1
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  set_i,
    input  logic  clr_i,
    input  logic  sw_i,
    input  word_t addr_i,
    input  logic  snoop_inv_i,
    input  word_t snoop_addr_i,
    output logic  link_ok_o
);
    logic  valid_q, valid_d;
    word_t addr_q, addr_d;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        if (clr_i)
            valid_d = 1'b0;
        if (sw_i && word_eq(addr_i, addr_q))
            valid_d = 1'b0;
        if (snoop_inv_i && word_eq(snoop_addr_i, addr_q))
            valid_d = 1'b0;
        // A retiring LL beats a same-cycle invalidate.
        if (set_i) begin
            valid_d = 1'b1;
            addr_d  = addr_i;
        end
        if (LINK_EN == 1'b0) begin
            valid_d = 1'b0;
            addr_d  = '0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    assign link_ok_o = (LINK_EN == 1'b0) ||
                       (valid_q && word_eq(addr_i, addr_q));
endmodule

// File: rtl/mem_access.sv
// Memory stage: turns EX/MEM loads/stores into held dcache requests,
// stalls upstream while outstanding and registers MEM/WB writeback.
module mem_access
    import cpu_types_pkg::*;
#(
    parameter bit LINK_EN = 1'b1
) (
    input  logic     CLK,
    input  logic     nRST,
    input  logic     valid_i,
    input  logic     memren_i,
    input  logic     memwen_i,
    input  logic     is_ll_i,
    input  logic     is_sc_i,
    input  word_t    addr_i,
    input  word_t    store_i,
    input  regbits_t dest_i,
    input  logic     regwen_i,
    input  logic     snoop_inv_i,
    input  word_t    snoop_addr_i,
    mem_access_if.master dc,
    output logic     stall_o,
    output logic     wb_valid_o,
    output logic     wb_wen_o,
    output regbits_t wb_dest_o,
    output word_t    wb_wdat_o
);
    mem_state_t state_q, state_d;
    logic       ren_q, ren_d, wen_q, wen_d;
    word_t      addr_q, addr_d, store_q, store_d;
    word_t      load_q, load_d;
    logic       wb_valid_q, wb_valid_d, wb_wen_q, wb_wen_d;
    regbits_t   wb_dest_q, wb_dest_d;
    word_t      wb_wdat_q, wb_wdat_d;
    logic       retire, done, link_ok;

    always_comb begin
        state_d    = state_q;
        ren_d      = ren_q;
        wen_d      = wen_q;
        addr_d     = addr_q;
        store_d    = store_q;
        load_d     = load_q;
        wb_valid_d = 1'b0;
        wb_wen_d   = 1'b0;
        wb_dest_d  = '0;
        wb_wdat_d  = '0;
        stall_o    = 1'b0;
        retire     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (is_sc_i && !link_ok) begin
                        retire    = 1'b1;
                        wb_wdat_d = '0;
                    end else if (memren_i || memwen_i) begin
                        stall_o = 1'b1;
                        ren_d   = memren_i;
                        wen_d   = memwen_i;
                        addr_d  = addr_i;
                        store_d = store_i;
                        state_d = ACCESS;
                    end else begin
                        retire    = 1'b1;
                        wb_wdat_d = addr_i;
                    end
                end
            end
            ACCESS: begin
                stall_o = 1'b1;
                if (dc.dhit) begin
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    load_d  = dc.dmemload;
                    state_d = DONE;
                end
            end
            DONE: begin
                retire  = 1'b1;
                state_d = IDLE;
                if (is_sc_i)
                    wb_wdat_d = 32'd1;
                else if (memren_i)
                    wb_wdat_d = load_q;
            end
            default: state_d = IDLE;
        endcase
        if (retire) begin
            wb_valid_d = 1'b1;
            wb_wen_d   = regwen_i;
            wb_dest_d  = dest_i;
        end
        if (state_q == DONE && memwen_i && !is_sc_i)
            wb_wen_d = 1'b0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            ren_q      <= 1'b0;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            store_q    <= '0;
            load_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_wen_q   <= 1'b0;
            wb_dest_q  <= '0;
            wb_wdat_q  <= '0;
        end else begin
            state_q    <= state_d;
            ren_q      <= ren_d;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
            store_q    <= store_d;
            load_q     <= load_d;
            wb_valid_q <= wb_valid_d;
            wb_wen_q   <= wb_wen_d;
            wb_dest_q  <= wb_dest_d;
            wb_wdat_q  <= wb_wdat_d;
        end
    end

    assign done = (state_q == DONE);

    link_reg #(.LINK_EN(LINK_EN)) u_link (
        .CLK          (CLK),
        .nRST         (nRST),
        .set_i        (done && is_ll_i),
        .clr_i        (retire && is_sc_i),
        .sw_i         (done && memwen_i && !is_sc_i),
        .addr_i       (addr_i),
        .snoop_inv_i  (snoop_inv_i),
        .snoop_addr_i (snoop_addr_i),
        .link_ok_o    (link_ok)
    );

    assign dc.dmemREN   = ren_q;
    assign dc.dmemWEN   = wen_q;
    assign dc.dmemaddr  = addr_q;
    assign dc.dmemstore = store_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_wen_o     = wb_wen_q;
    assign wb_dest_o    = wb_dest_q;
    assign wb_wdat_o    = wb_wdat_q;
endmodule

// File: doc/mem_access.md
# mem_access

Memory stage of the pipeline, directly downstream of the EX/MEM latch. It takes the latched execute result and turns loads and stores into held dcache requests. It maintains the LL/SC link register and registers the retiring instruction's writeback data toward MEM/WB. It also drives the stall that freezes the upstream latches while a data access is outstanding.

## Interface
Parameters:
- LINK_EN, 1, enables the LL/SC link register. When 0, every SC behaves as SW and writes 1 to rt.

Ports:
- CLK  in  1  pipeline clock
- nRST  in  1  asynchronous active-low reset
- valid_i  in  1  the EX/MEM latch holds a real instruction
- memren_i  in  1  load (LW or LL)
- memwen_i  in  1  store (SW or SC)
- is_ll_i  in  1  instruction is LL
- is_sc_i  in  1  instruction is SC
- addr_i  in  32  ALU result; the memory address or the non-memory result
- store_i  in  32  store data
- dest_i  in  5  destination register
- regwen_i  in  1  writeback enable
- dhit  in  1  dcache access complete
- dmemload  in  32  dcache read data
- snoop_inv_i  in  1  coherence invalidate this cycle
- snoop_addr_i  in  32  invalidated address
- dmemREN  out  1  registered read request
- dmemWEN  out  1  registered write request
- dmemaddr  out  32  request address
- dmemstore  out  32  write data
- stall_o  out  1  freeze the IF/ID, ID/EX and EX/MEM latches
- wb_valid_o  out  1  writeback slot holds an instruction
- wb_wen_o  out  1  register-file write enable
- wb_dest_o  out  5  writeback register
- wb_wdat_o  out  32  writeback data

## Operation
- State machine has three states: IDLE, ACCESS, DONE.
- IDLE with a valid non-memory instruction: retire it the same cycle. wb_wdat = addr_i, stall_o=0.
- IDLE with a valid memory op: stall_o=1. Load dmemREN/WEN, dmemaddr and dmemstore. Go to ACCESS.
- IDLE with an SC whose link fails: no cache access. Retire with wb_wdat=0, stall_o=0.
- The link fails when link_valid=0 or link_addr[31:2]≠addr_i[31:2].
- ACCESS: hold the request and keep stall_o=1. On dhit, drop the request, capture dmemload into load_q, and go to DONE.
- DONE: stall_o=0 and retire, then return to IDLE.
  - Load and LL retire with wb_wdat=load_q.
  - SC retires with wb_wdat=1.
  - SW retires with wb_wen=0.
- Link register:
  - LL retiring in DONE sets link_valid=1 and link_addr=addr.
  - A retiring SC (pass or fail) clears the link.
  - An SW retiring to link_addr clears the link.
  - snoop_inv_i with a word match clears the link.
- Simultaneous events:
  - LL retire and snoop in the same cycle: the LL set wins.
  - A snoop during ACCESS of an SC does not abort it; the link is checked only in IDLE.
- Any cycle without a retirement drives wb_valid_o=0 and wb_wen_o=0 (bubble).
- An invalid instruction (valid_i=0) is ignored in IDLE.

## Timing
- Reset: state=IDLE and all outputs 0, including dmemREN, dmemWEN, dmemaddr, dmemstore, stall_o and all wb_* outputs. Link register cleared. Reset mid-ACCESS drops the request immediately.
- Non-memory op or failed SC: wb_* outputs valid one cycle after presentation.
- Memory op latency is N+2 cycles, where N ≥ 1 is the number of ACCESS cycles up to and including dhit. The wb_* outputs are valid the cycle after DONE.
- dhit is ignored outside ACCESS.
- dmem* outputs are stable for the whole of ACCESS.
- Upstream advances only on cycles with stall_o=0. The instruction is held unchanged during IDLE→ACCESS→DONE.

## Structure
- cpu_types_pkg holds:
  - word_t (32) and regbits_t (5)
  - the mem_state_t enum {IDLE, ACCESS, DONE}
- The link register, with its set, clear and compare logic, is natural as a sub-module, link_reg. It takes LINK_EN and exposes link_ok.

## Test plan
- ADD result 0x0000_0010 to dest 3, valid_i=1 → next cycle wb_valid=1, wb_dest=3, wb_wdat=0x10, stall_o never 1.
- LW at 0x100, dhit on the 3rd ACCESS cycle with dmemload=0xDEAD_BEEF:
  - dmemREN=1 and dmemaddr=0x100 for exactly 3 cycles.
  - stall_o high 4 cycles.
  - wb_wdat=0xDEAD_BEEF.
- LL at 0x200, then SC at 0x200 with store 0x55 → dmemWEN with dmemstore=0x55, wb_wdat=1, link cleared afterwards.
- LL at 0x200, then snoop_inv at 0x204 (no match), then SC at 0x200 → success.
  - Repeat with a snoop at 0x200 → no dmemWEN, wb_wdat=0.
- SC at 0x300 with no prior LL → no cache request, wb_wdat=0, one-cycle retirement.
- nRST asserted mid-ACCESS of an SW → dmemWEN=0 immediately and state IDLE. After release, an instruction presented in IDLE starts a fresh request.
